// File: rtl/serial_subtractor_pkg.sv
// serial_subtractor_pkg: shared FSM state type and default width for the bit-serial subtractor.
package serial_sub_pkg;
  localparam int DEFAULT_WIDTH = 8;
  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;
endpackage

// File: rtl/serial_subtractor_if.sv
// serial_subtractor_if: start/done handshake and operand/result bus; SUB_OVERFLOW_EN adds ovf.
interface serial_subtractor_if import serial_sub_pkg::*; #(parameter int WIDTH = DEFAULT_WIDTH);
  logic start;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic bin;
  logic ready;
  logic busy;
  logic done;
  logic [WIDTH-1:0] diff;
  logic bout;
  logic [WIDTH:0] result;
`ifdef SUB_OVERFLOW_EN
  logic ovf;
  modport master (output start, a, b, bin, input ready, busy, done, diff, bout, result, ovf);
  modport slave (input start, a, b, bin, output ready, busy, done, diff, bout, result, ovf);
`else
  modport master (output start, a, b, bin, input ready, busy, done, diff, bout, result);
  modport slave (input start, a, b, bin, output ready, busy, done, diff, bout, result);
`endif
endinterface

// File: rtl/serial_subtractor_full_subtractor.sv
// full_subtractor: one-bit x - y - br_in with borrow-out.
module full_subtractor (
  input  logic x,
  input  logic y,
  input  logic br_in,
  output logic d,
  output logic br_out
);
  assign d = x ^ y ^ br_in;
  assign br_out = (~x & y) | (~(x ^ y) & br_in);
endmodule

// File: rtl/serial_subtractor.sv
// serial_subtractor: LSB-first bit-serial a - b - bin with start/done handshake; SUB_OVERFLOW_EN adds signed-overflow flag ovf.
module serial_subtractor import serial_sub_pkg::*; #(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input logic clk,
  input logic rst_n,
  serial_subtractor_if.slave bus
);
  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);
  state_t state;
  logic [WIDTH-1:0] a_sh, b_sh, diff_sh, diff, diff_next;
  logic [CW-1:0] count;
  logic br, br_next, d, ready, busy, done, bout;
  full_subtractor fs (.x(a_sh[0]), .y(b_sh[0]), .br_in(br), .d(d), .br_out(br_next));
  assign diff_next = {d, diff_sh[WIDTH-1:1]};
  assign bus.ready = ready;
  assign bus.busy = busy;
  assign bus.done = done;
  assign bus.diff = diff;
  assign bus.bout = bout;
  assign bus.result = {bout, diff};
`ifdef SUB_OVERFLOW_EN
  // operand MSBs are shifted out during SHIFT, so keep them for the overflow test
  logic a_msb, b_msb, ovf;
  assign bus.ovf = ovf;
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      a_msb <= 1'b0;
      b_msb <= 1'b0;
      ovf <= 1'b0;
    end else if (state == IDLE && bus.start) begin
      a_msb <= bus.a[WIDTH-1];
      b_msb <= bus.b[WIDTH-1];
    end else if (state == SHIFT && count == LAST) begin
      ovf <= (a_msb != b_msb) && (d != a_msb);
    end
  end
`endif
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= IDLE;
      a_sh <= '0;
      b_sh <= '0;
      diff_sh <= '0;
      br <= 1'b0;
      count <= '0;
      ready <= 1'b1;
      busy <= 1'b0;
      done <= 1'b0;
      diff <= '0;
      bout <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: if (bus.start) begin
          a_sh <= bus.a;
          b_sh <= bus.b;
          br <= bus.bin;
          count <= '0;
          ready <= 1'b0;
          busy <= 1'b1;
          state <= SHIFT;
        end
        SHIFT: begin
          a_sh <= a_sh >> 1;
          b_sh <= b_sh >> 1;
          diff_sh <= diff_next;
          br <= br_next;
          count <= count + CW'(1);
          if (count == LAST) begin
            diff <= diff_next;
            bout <= br_next;
            busy <= 1'b0;
            done <= 1'b1;
            state <= DONE;
          end
        end
        default: begin
          ready <= 1'b1;
          state <= IDLE;
        end
      endcase
    end
  end
endmodule
